// File: rtl/level_search_3bit.sv
// MSB-first successive-approximation search that recovers a sensor level through a magnitude comparator.
// Optional build macro SEARCH_EARLY_EXIT_EN ends the search on the first eq flag.
module level_search_3bit #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    output logic [WIDTH-1:0] cand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] level,
    output logic             err
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StProbe,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             flags_ok;
    logic             finish;
    logic [WIDTH-1:0] decided;

    // A healthy comparator asserts exactly one of its three flags.
    assign flags_ok = ({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) ||
                      ({gt, eq, lt} == 3'b001);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        level_d = level_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        finish  = 1'b0;
        decided = cand_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cand_d  = WIDTH'(1) << (WIDTH - 1);
                    bit_d   = BW'(WIDTH - 1);
                    wait_d  = WW'(SETTLE);
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = StProbe;
                end
            end
            StProbe: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else if (!flags_ok) begin
                    err_d   = 1'b1;
                    level_d = '0;
                    finish  = 1'b1;
                end else begin
                    if (lt) begin
                        decided[bit_q] = 1'b0;
                    end
`ifdef SEARCH_EARLY_EXIT_EN
                    if (eq) begin
                        level_d = cand_q;
                        finish  = 1'b1;
                    end else
`endif
                    if (bit_q == '0) begin
                        level_d = decided;
                        finish  = 1'b1;
                    end else begin
                        cand_d = decided | (WIDTH'(1) << (bit_q - 1'b1));
                        bit_d  = bit_q - 1'b1;
                        wait_d = WW'(SETTLE);
                    end
                end
            end
            StFinish: begin
                // Done pulse cycle; a start seen here is dropped, not queued.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cand_d  = '0;
            state_d = StFinish;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cand_q  <= '0;
            level_q <= '0;
            bit_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            level_q <= level_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cand  = cand_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign level = level_q;
    assign err   = err_q;

endmodule
